// File: rtl/implication_pkg.sv
// Shared constants and the per-channel status bundle for the implication monitor.
package implication_pkg;

    localparam int MAX_DELAY_LIMIT = 15;
    localparam int NUM_CH_LIMIT    = 8;
    // Counts travel in the status bundle at their widest legal size; the top
    // narrows them back to CNT_W.
    localparam int CNT_W_LIMIT     = 32;

    typedef struct packed {
        logic                   pass;
        logic                   fail;
        logic [CNT_W_LIMIT-1:0] pass_cnt;
        logic [CNT_W_LIMIT-1:0] fail_cnt;
    } chan_status_t;

endpackage

// File: rtl/implication_channel.sv
// One antecedent/consequent channel: tracks attempt ages, discharges them on a
// consequent inside the window, flags expiries and keeps saturating counts.
module implication_channel
    import implication_pkg::*;
#(
    parameter int MIN_DELAY = 1,
    parameter int MAX_DELAY = 3,
    parameter int CNT_W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable_i,
    input  logic         clear_i,
    input  logic         ante_i,
    input  logic         cons_i,
    output logic         fail_nxt_o,
    output chan_status_t status_o
);

    localparam int AW = MAX_DELAY + 1;
    localparam logic [AW-1:0]    ONES    = '1;
    // Ages MIN_DELAY..MAX_DELAY are the ones a consequent may discharge.
    localparam logic [AW-1:0]    WIN     = ONES << MIN_DELAY;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [AW-1:0]    pend_q, pend_d;
    logic [AW-1:0]    cur, hit;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;

    // Age existing attempts, insert the new one, discharge and expire.
    always_comb begin
        cur    = (pend_q << 1) | AW'(ante_i & enable_i);
        hit    = cur & WIN & {AW{cons_i}};
        pass_d = |hit;
        fail_d = cur[MAX_DELAY] & ~hit[MAX_DELAY];
        pend_d = cur & ~hit;
        // The oldest slot either passed or failed this cycle; never carried.
        pend_d[MAX_DELAY] = 1'b0;
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        if (pass_d && pass_cnt_q != CNT_MAX) pass_cnt_d = pass_cnt_q + CNT_W'(1);
        if (fail_d && fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + CNT_W'(1);
        if (clear_i) begin
            pend_d     = '0;
            pass_d     = 1'b0;
            fail_d     = 1'b0;
            pass_cnt_d = '0;
            fail_cnt_d = '0;
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q     <= '0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            pend_q     <= pend_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    // Pack the registered status for the top.
    always_comb begin
        status_o.pass     = pass_q;
        status_o.fail     = fail_q;
        status_o.pass_cnt = CNT_W_LIMIT'(pass_cnt_q);
        status_o.fail_cnt = CNT_W_LIMIT'(fail_cnt_q);
    end

    assign fail_nxt_o = fail_d;

endmodule

// File: rtl/implication_monitor.sv
// Multi-channel implication monitor: per-channel checkers plus sticky
// any-fail status and first-failing-channel capture.
module implication_monitor
    import implication_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int MIN_DELAY = 1,
    parameter int MAX_DELAY = 3,
    parameter int CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable_i,
    input  logic                    clear_i,
    input  logic [NUM_CH-1:0]       antecedent_i,
    input  logic [NUM_CH-1:0]       consequent_i,
    output logic [NUM_CH-1:0]       pass_o,
    output logic [NUM_CH-1:0]       fail_o,
    output logic [NUM_CH*CNT_W-1:0] pass_cnt_o,
    output logic [NUM_CH*CNT_W-1:0] fail_cnt_o,
    output logic                    any_fail_o,
    output logic [2:0]              first_fail_ch_o
);

    if (MIN_DELAY < 0 || MIN_DELAY > MAX_DELAY || MAX_DELAY > MAX_DELAY_LIMIT) begin : g_bad_delay
        $error("implication_monitor: illegal MIN_DELAY/MAX_DELAY");
    end
    if (NUM_CH < 1 || NUM_CH > NUM_CH_LIMIT) begin : g_bad_ch
        $error("implication_monitor: NUM_CH out of range");
    end
    if (CNT_W < 1 || CNT_W > CNT_W_LIMIT) begin : g_bad_cnt
        $error("implication_monitor: CNT_W out of range");
    end

    chan_status_t      st [NUM_CH];
    logic [NUM_CH-1:0] fail_nxt;
    logic              any_fail_q, any_fail_d;
    logic [2:0]        first_q, first_d;
    logic [2:0]        low_ch;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        implication_channel #(
            .MIN_DELAY (MIN_DELAY),
            .MAX_DELAY (MAX_DELAY),
            .CNT_W     (CNT_W)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .enable_i   (enable_i),
            .clear_i    (clear_i),
            .ante_i     (antecedent_i[c]),
            .cons_i     (consequent_i[c]),
            .fail_nxt_o (fail_nxt[c]),
            .status_o   (st[c])
        );
        assign pass_o[c]                  = st[c].pass;
        assign fail_o[c]                  = st[c].fail;
        assign pass_cnt_o[c*CNT_W +: CNT_W] = CNT_W'(st[c].pass_cnt);
        assign fail_cnt_o[c*CNT_W +: CNT_W] = CNT_W'(st[c].fail_cnt);
    end

    // Sticky flag and first-fail index latch on the edge the first fail_o rises.
    always_comb begin
        low_ch = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (fail_nxt[c]) low_ch = 3'(c);
        end
        any_fail_d = any_fail_q;
        first_d    = first_q;
        if (!any_fail_q && (|fail_nxt)) begin
            any_fail_d = 1'b1;
            first_d    = low_ch;
        end
        if (clear_i) begin
            any_fail_d = 1'b0;
            first_d    = '0;
        end
    end

    // Sticky status register with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_fail_q <= 1'b0;
            first_q    <= '0;
        end else begin
            any_fail_q <= any_fail_d;
            first_q    <= first_d;
        end
    end

    assign any_fail_o      = any_fail_q;
    assign first_fail_ch_o = first_q;

endmodule
